// File: rtl/iir_fold3_mult_stage_if.sv
// -----------------------------------------------------------------------------
// iir_fold3_mult_stage_if
// Handshake and datapath bundle between the upstream sample source, the
// folded multiplier stage and the downstream adder/delay register.
//   in_valid / in_ready : sample handshake (accept = in_valid && in_ready)
//   x_in, coef0..coef2  : sample and per-phase coefficients, captured on accept
//   fb_in               : feedback operand, read live in phases 1 and 2
//   prod_out            : registered rounded/saturated product
//   prod_valid          : prod_out carries a new product this cycle
//   prod_phase          : phase index (0,1,2) of prod_out
//   sample_done         : pulses with the phase-2 product
//   sat_flag            : pulses with any saturated product
// master = upstream/downstream environment, slave = the multiplier stage.
// -----------------------------------------------------------------------------
interface iir_fold3_mult_stage_if #(
   parameter int W = 20
) ();
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x_in;
   logic [W-1:0] coef0;
   logic [W-1:0] coef1;
   logic [W-1:0] coef2;
   logic [W-1:0] fb_in;
   logic [W-1:0] prod_out;
   logic         prod_valid;
   logic [1:0]   prod_phase;
   logic         sample_done;
   logic         sat_flag;

   modport master (
      output in_valid, x_in, coef0, coef1, coef2, fb_in,
      input  in_ready, prod_out, prod_valid, prod_phase, sample_done, sat_flag
   );

   modport slave (
      input  in_valid, x_in, coef0, coef1, coef2, fb_in,
      output in_ready, prod_out, prod_valid, prod_phase, sample_done, sat_flag
   );
endinterface

// File: rtl/iir_fold3_mult_stage.sv
// -----------------------------------------------------------------------------
// iir_fold3_mult_stage
// Folded multiplier stage of the 3-folded IIR datapath. One signed W x W
// multiplier is shared over three phases per accepted sample:
//   P0: x * coef0, P1: fb * coef1, P2: fb * coef2
// Each product is rounded half-up back to Q8.12 and saturated to W bits, then
// registered. A new sample may be accepted in IDLE or in P2 (back-to-back).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : iir_fold3_mult_stage_if.slave (handshake, operands, product outputs)
// -----------------------------------------------------------------------------
module iir_fold3_mult_stage #(
   parameter int W    = 20,
   parameter int FRAC = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   iir_fold3_mult_stage_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      P0   = 2'd1,
      P1   = 2'd2,
      P2   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic signed [W-1:0] x_q, c0_q, c1_q, c2_q;
   logic signed [W-1:0] prod_q;
   logic [1:0]          phase_q, phase_d;
   logic                vld_q, done_q, sat_q;

   logic                accept;
   logic signed [W-1:0] op_a, op_b;
   logic signed [2*W-1:0] mult;
   logic [W:0]          rs;          // {saturated, value}
   logic                unused_lsb;

   // Rounds the product (given from bit FRAC-1 upward) half-up and saturates.
   // hi[0] is product bit FRAC-1, so adding it is the same as adding
   // 2^(FRAC-1) and dropping the fraction. r is the product shifted right by
   // FRAC with one extra sign bit; it fits in W bits only when its top
   // W-FRAC+2 bits are all copies of the sign.
   function automatic logic [W:0] round_sat(input logic [2*W-FRAC:0] hi);
      logic [2*W-FRAC:0] r;
      logic [W:0]        res;
      r = {hi[2*W-FRAC], hi[2*W-FRAC:1]} + {{(2*W-FRAC){1'b0}}, hi[0]};
      if (r[2*W-FRAC:W-1] == {(W-FRAC+2){r[2*W-FRAC]}}) begin
         res = {1'b0, r[W-1:0]};
      end else if (r[2*W-FRAC]) begin
         res = {1'b1, 1'b1, {(W-1){1'b0}}};
      end else begin
         res = {1'b1, 1'b0, {(W-1){1'b1}}};
      end
      return res;
   endfunction

   // Ready is a pure function of state, so it is high throughout reset.
   assign bus.in_ready = (state_q == IDLE) || (state_q == P2);

   always_comb begin
      accept  = bus.in_valid && bus.in_ready;
      state_d = state_q;
      phase_d = 2'd0;
      op_a    = x_q;
      op_b    = c0_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = P0;
         end
         P0: begin
            state_d = P1;
         end
         P1: begin
            state_d = P2;
            phase_d = 2'd1;
            op_a    = $signed(bus.fb_in);
            op_b    = c1_q;
         end
         P2: begin
            state_d = accept ? P0 : IDLE;
            phase_d = 2'd2;
            op_a    = $signed(bus.fb_in);
            op_b    = c2_q;
         end
         default: state_d = IDLE;
      endcase
      mult = op_a * op_b;
      rs   = round_sat(mult[2*W-1:FRAC-1]);
   end

   // Bits below FRAC-1 never reach the output; round-half-up only needs bit FRAC-1.
   assign unused_lsb = ^mult[FRAC-2:0];

   // ---- operand capture / phase sequencing -> product register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         c0_q    <= '0;
         c1_q    <= '0;
         c2_q    <= '0;
         prod_q  <= '0;
         phase_q <= 2'd0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // A P2 accept overwrites c2_q only after this cycle's P2 product used it.
         if (accept) begin
            x_q  <= $signed(bus.x_in);
            c0_q <= $signed(bus.coef0);
            c1_q <= $signed(bus.coef1);
            c2_q <= $signed(bus.coef2);
         end
         if (state_q != IDLE) begin
            prod_q  <= $signed(rs[W-1:0]);
            phase_q <= phase_d;
            vld_q   <= 1'b1;
            done_q  <= (state_q == P2);
            sat_q   <= rs[W];
         end else begin
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
         end
      end
   end

   assign bus.prod_out    = prod_q;
   assign bus.prod_phase  = phase_q;
   assign bus.prod_valid  = vld_q;
   assign bus.sample_done = done_q;
   assign bus.sat_flag    = sat_q;

endmodule
